multicycle_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the 8-bit processor datapath. Walks each instruction through

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/opcode_class_decode.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//  Shared definitions for the multi-cycle control sequencer:
//   - RISC-V style major opcode constants recognised by the sequencer
//   - ALU operation class encodings driven on Aluop
//   - sequencer state enum and instruction-class enum
//   - aluop_for(): maps an instruction class to its ALU operation class
// ----------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_ITYPE   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_e;

    function automatic logic [1:0] aluop_for(input instr_class_e cls);
        logic [1:0] r;
        r = ALUOP_LDST;
        if (cls == CLS_RTYPE) r = ALUOP_RTYPE;
        else if (cls == CLS_ITYPE) r = ALUOP_ITYPE;
        return r;
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// ----------------------------------------------------------------------------
// opcode_class_decode
//  Purely combinational classification of an opcode into one of the
//  instruction classes the sequencer understands.
//  Ports:
//   i_opcode  in  OPCODE_W  opcode to classify
//   o_class   out class     LOAD / STORE / RTYPE / ITYPE / ILLEGAL
//  For OPCODE_W wider than 7 the upper bits must be zero for a match.
// ----------------------------------------------------------------------------
module opcode_class_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
)
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output instr_class_e        o_class
);

    // Compare at a common width so narrower or wider opcode fields work.
    localparam int CW = (OPCODE_W > 7) ? OPCODE_W : 7;

    logic [CW-1:0] w_op_ext;

    assign w_op_ext = CW'(i_opcode);

    always_comb begin
        o_class = CLS_ILLEGAL;
        if (w_op_ext == CW'(OP_LOAD))       o_class = CLS_LOAD;
        else if (w_op_ext == CW'(OP_STORE)) o_class = CLS_STORE;
        else if (w_op_ext == CW'(OP_RTYPE)) o_class = CLS_RTYPE;
        else if (w_op_ext == CW'(OP_ITYPE)) o_class = CLS_ITYPE;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//  Multi-cycle control sequencer: walks each instruction through
//  FETCH / DECODE / EXEC / MEM / WB, handshaking with instruction and data
//  memory, and drives datapath controls from the current state and the
//  latched opcode. Counts retired instructions.
//
//  Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   : unknown opcode in DECODE enters TRAP (illegal_op=1, sticky,
//               everything else 0, leaves only through rst_n)
//   undefined : unknown opcode retires as a NOP, illegal_op tied 0
//
//  Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                run enable; 0 freezes state/opcode/counter and
//                     suppresses the strobes ir_we, pc_we, regwrite
//   imem_req/imem_ack instruction fetch handshake, opcode sampled on ack
//   opcode            instruction opcode field
//   ir_we, pc_we      instruction-register write / PC-advance strobes
//   dmem_req/dmem_ack data memory handshake
//   memread, memwrite, memtoreg, aluSrc, regwrite, Aluop  datapath controls
//   illegal_op        sticky illegal-opcode flag
//   instr_count       retired-instruction count, wraps modulo 2^COUNT_W
// ----------------------------------------------------------------------------
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2,
    parameter int COUNT_W  = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                ir_we,
    output logic                pc_we,
    output logic                dmem_req,
    input  logic                dmem_ack,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                aluSrc,
    output logic                regwrite,
    output logic [ALUOP_W-1:0]  Aluop,
    output logic                illegal_op,
    output logic [COUNT_W-1:0]  instr_count
);

    state_e              r_state;
    state_e              w_state_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [COUNT_W-1:0]  r_count;
    instr_class_e        w_class;
    logic [1:0]          w_aluop;

    // Classification always works on the latched opcode, never the live bus.
    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode (r_opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_opcode <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (ir_we) begin
                r_opcode <= opcode;
            end
            // Every retirement is marked by exactly one pc_we pulse.
            if (pc_we) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    // Level outputs depend only on state and latched opcode; the strobes are
    // additionally qualified by en (and by the ack where the state waits).
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        dmem_req     = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        memtoreg     = 1'b0;
        aluSrc       = 1'b0;
        regwrite     = 1'b0;
        w_aluop      = ALUOP_LDST;

        case (r_state)
            IDLE: begin
                if (en) w_state_next = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (en && imem_ack) begin
                    ir_we        = 1'b1;
                    w_state_next = DECODE;
                end
            end

            DECODE: begin
                if (en) begin
                    if (w_class == CLS_ILLEGAL) begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_state_next = TRAP;
`else
                        // Unknown opcode retires as a NOP.
                        pc_we        = 1'b1;
                        w_state_next = FETCH;
`endif
                    end else begin
                        w_state_next = EXEC;
                    end
                end
            end

            EXEC: begin
                aluSrc  = (w_class != CLS_RTYPE);
                w_aluop = aluop_for(w_class);
                if (en) begin
                    if (w_class == CLS_LOAD || w_class == CLS_STORE)
                        w_state_next = MEM;
                    else
                        w_state_next = WB;
                end
            end

            MEM: begin
                dmem_req = 1'b1;
                aluSrc   = 1'b1;
                w_aluop  = ALUOP_LDST;
                memread  = (w_class == CLS_LOAD);
                memwrite = (w_class != CLS_LOAD);
                if (en && dmem_ack) begin
                    if (w_class == CLS_LOAD) begin
                        w_state_next = WB;
                    end else begin
                        // A store retires straight out of MEM.
                        pc_we        = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end

            WB: begin
                memtoreg = (w_class == CLS_LOAD);
                if (en) begin
                    regwrite     = 1'b1;
                    pc_we        = 1'b1;
                    w_state_next = FETCH;
                end
            end

`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                w_state_next = TRAP;
            end
`endif

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign Aluop       = ALUOP_W'(w_aluop);
    assign instr_count = r_count;

`ifdef ILLEGAL_OP_TRAP_EN
    // TRAP is only left through reset, so the state itself is the sticky flag.
    assign illegal_op = (r_state == TRAP);
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//  Self-checking bench for multicycle_control_fsm (COUNT_W=4 so the counter
//  wrap is reachable quickly). Directed vector table, hand sequences for the
//  async reset, unknown opcode and counter wrap, then randomized traffic
//  checked against an instruction-level reference model.
// ----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam int OPCODE_W = 7;
    localparam int ALUOP_W  = 2;
    localparam int COUNT_W  = 4;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_RTYPE = 7'b0110011;
    localparam logic [6:0] T_ITYPE = 7'b0010011;
    localparam logic [6:0] T_BAD   = 7'b1111111;

    // Instruction phases used by the reference model.
    localparam int P_D = 1;
    localparam int P_E = 2;
    localparam int P_M = 3;
    localparam int P_W = 4;
    localparam int P_T = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                imem_ack = 1'b0;
    logic                dmem_ack = 1'b0;
    logic [OPCODE_W-1:0] opcode = '0;
    logic                imem_req, ir_we, pc_we, dmem_req;
    logic                memread, memwrite, memtoreg, aluSrc, regwrite;
    logic [ALUOP_W-1:0]  Aluop;
    logic                illegal_op;
    logic [COUNT_W-1:0]  instr_count;

    multicycle_control_fsm #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .opcode      (opcode),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .aluSrc      (aluSrc),
        .regwrite    (regwrite),
        .Aluop       (Aluop),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Output vector: {imem_req, ir_we, pc_we, dmem_req, memread, memwrite,
    //                 memtoreg, aluSrc, regwrite, Aluop[1:0], illegal_op}
    function automatic logic [11:0] outs();
        return {imem_req, ir_we, pc_we, dmem_req, memread, memwrite,
                memtoreg, aluSrc, regwrite, Aluop, illegal_op};
    endfunction

    task automatic chk12(input string name, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: outputs got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [COUNT_W-1:0] got, input logic [COUNT_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: instr_count got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    bit          model_on = 1'b0;
    bit          m_run;
    int          m_q[$];
    logic [6:0]  m_op;
    int          m_cnt;
    int          m_retired;

    function automatic bit is_legal(input logic [6:0] o);
        return (o == T_LOAD) || (o == T_STORE) || (o == T_RTYPE) || (o == T_ITYPE);
    endfunction

    function automatic void model_reset();
        m_run = 1'b0;
        m_q.delete();
        m_op = '0;
        m_cnt = 0;
    endfunction

    // Returns expected outputs for this cycle, then advances past the edge.
    task automatic model_cycle(input logic e, input logic ia, input logic da,
                               input logic [6:0] op, output logic [11:0] exp);
        logic imr, irw, pcw, dmr, mrd, mwr, mtr, als, rgw, ill;
        logic [1:0] aop;
        int cur;
        imr = 0; irw = 0; pcw = 0; dmr = 0; mrd = 0; mwr = 0;
        mtr = 0; als = 0; rgw = 0; ill = 0; aop = 2'b00;
        // 0 = idle, -1 = waiting for fetch, else the phase at queue head
        cur = !m_run ? 0 : (m_q.size() == 0 ? -1 : m_q[0]);
        if (cur == -1) begin
            imr = 1; irw = e & ia;
        end else if (cur == P_D) begin
            if (!is_legal(m_op) && !TRAP_BUILD) pcw = e;
        end else if (cur == P_E) begin
            als = (m_op != T_RTYPE);
            aop = (m_op == T_RTYPE) ? 2'b10 : (m_op == T_ITYPE) ? 2'b11 : 2'b00;
        end else if (cur == P_M) begin
            dmr = 1; als = 1;
            mrd = (m_op == T_LOAD);
            mwr = (m_op == T_STORE);
            pcw = e & da & (m_op == T_STORE);
        end else if (cur == P_W) begin
            rgw = e; pcw = e; mtr = (m_op == T_LOAD);
        end else if (cur == P_T) begin
            ill = 1;
        end
        exp = {imr, irw, pcw, dmr, mrd, mwr, mtr, als, rgw, aop, ill};
        if (e) begin
            if (cur == 0) begin
                m_run = 1'b1;
            end else if (cur == -1) begin
                if (ia) begin
                    m_op = op;
                    if (op == T_LOAD)        m_q = '{P_D, P_E, P_M, P_W};
                    else if (op == T_STORE)  m_q = '{P_D, P_E, P_M};
                    else if (is_legal(op))   m_q = '{P_D, P_E, P_W};
                    else if (TRAP_BUILD)     m_q = '{P_D, P_T};
                    else                     m_q = '{P_D};
                end
            end else if (cur == P_M) begin
                if (da) void'(m_q.pop_front());
            end else if (cur != P_T) begin
                void'(m_q.pop_front());
            end
        end
        if (pcw) begin
            m_cnt = (m_cnt + 1) % (1 << COUNT_W);
            m_retired++;
            $display("[TB] retire #%0d opcode=%b expected count=%0d", m_retired, m_op, m_cnt);
        end
    endtask

    // One clock: drive inputs just after the edge, check at the falling edge.
    task automatic cyc(input logic e, input logic ia, input logic da, input logic [6:0] op,
                       input bit hx, input logic [11:0] hexp, input logic [3:0] hcnt,
                       input string tag);
        logic [11:0] mexp;
        en = e; imem_ack = ia; dmem_ack = da; opcode = op;
        @(negedge clk);
        if (hx) begin
            chk12({tag, "_outs"}, outs(), hexp);
            chkc({tag, "_cnt"}, instr_count, hcnt);
        end
        if (model_on) begin
            chkc({tag, "_model_cnt"}, instr_count, m_cnt[COUNT_W-1:0]);
            model_cycle(e, ia, da, op, mexp);
            chk12({tag, "_model_outs"}, outs(), mexp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk12("reset_outs", outs(), 12'b0);
        chkc("reset_cnt", instr_count, '0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        e;
        logic        ia;
        logic        da;
        logic [6:0]  op;
        logic [11:0] exp;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic ia, input logic da, input logic [6:0] op,
                                input logic [11:0] exp, input logic [3:0] cnt);
        vec_t v;
        v.e = e; v.ia = ia; v.da = da; v.op = op; v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // IDLE, fetch RTYPE, LOAD with 3 wait cycles, STORE with en=0 in MEM, ITYPE
        tbl.push_back(mk(0, 0, 0, 7'd0,    12'b000000000000, 4'd0));
        tbl.push_back(mk(1, 1, 0, 7'd0,    12'b000000000000, 4'd0));
        tbl.push_back(mk(1, 1, 0, T_RTYPE, 12'b110000000000, 4'd0));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000000000, 4'd0));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000000100, 4'd0));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b001000001000, 4'd0));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b100000000000, 4'd1));
        tbl.push_back(mk(1, 1, 0, T_LOAD,  12'b110000000000, 4'd1));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000000000, 4'd1));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000010000, 4'd1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 0, 7'd0, 12'b000110010000, 4'd1));
        tbl.push_back(mk(1, 0, 1, 7'd0,    12'b000110010000, 4'd1));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b001000101000, 4'd1));
        tbl.push_back(mk(1, 1, 0, T_STORE, 12'b110000000000, 4'd2));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000000000, 4'd2));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000010000, 4'd2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 1, 7'd0, 12'b000101010000, 4'd2));
        tbl.push_back(mk(1, 0, 1, 7'd0,    12'b001101010000, 4'd2));
        tbl.push_back(mk(1, 0, 1, 7'd0,    12'b100000000000, 4'd3));
        tbl.push_back(mk(0, 1, 0, T_LOAD,  12'b100000000000, 4'd3));
        tbl.push_back(mk(1, 1, 0, T_ITYPE, 12'b110000000000, 4'd3));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000000000, 4'd3));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b000000010110, 4'd3));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b001000001000, 4'd3));
        tbl.push_back(mk(1, 0, 0, 7'd0,    12'b100000000000, 4'd4));

        do_reset();

        model_on = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            $display("[TB] vec %0d en=%b ia=%b da=%b op=%b exp=%b cnt=%0d",
                     i, tbl[i].e, tbl[i].ia, tbl[i].da, tbl[i].op, tbl[i].exp, tbl[i].cnt);
            cyc(tbl[i].e, tbl[i].ia, tbl[i].da, tbl[i].op, 1'b1, tbl[i].exp, tbl[i].cnt,
                $sformatf("vec%0d", i));
        end

        // Async reset in the middle of a LOAD's MEM phase
        $display("[TB] seq async reset mid-MEM");
        cyc(1, 1, 0, T_LOAD, 1'b0, '0, '0, "rst_f");
        cyc(1, 0, 0, 7'd0,   1'b0, '0, '0, "rst_d");
        cyc(1, 0, 0, 7'd0,   1'b0, '0, '0, "rst_e");
        en = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2;
        chk12("pre_reset_mem_outs", outs(), 12'b000110010000);
        chkc("pre_reset_mem_cnt", instr_count, 4'd4);
        rst_n = 1'b0;
        #1;
        chk12("async_reset_outs", outs(), 12'b0);
        chkc("async_reset_cnt", instr_count, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        model_on = 1'b1;
        m_retired = 0;
        cyc(0, 0, 0, 7'd0, 1'b1, 12'b0, 4'd0, "post_reset_idle");

        // Unknown opcode 7'b1111111
        $display("[TB] seq unknown opcode");
        cyc(1, 0, 0, 7'd0,  1'b1, 12'b000000000000, 4'd0, "bad_idle");
        cyc(1, 1, 0, T_BAD, 1'b1, 12'b110000000000, 4'd0, "bad_fetch");
`ifdef ILLEGAL_OP_TRAP_EN
        cyc(1, 0, 0, 7'd0, 1'b1, 12'b000000000000, 4'd0, "bad_decode");
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 1, T_LOAD, 1'b1, 12'b000000000001, 4'd0, $sformatf("trap%0d", i));
        do_reset();
        model_on = 1'b1;
`else
        cyc(1, 0, 0, 7'd0, 1'b1, 12'b001000000000, 4'd0, "nop_decode");
        cyc(1, 0, 0, 7'd0, 1'b1, 12'b100000000000, 4'd1, "nop_fetch");
        do_reset();
        model_on = 1'b1;
`endif

        // Counter wrap: 16 retirements bring the 4-bit count back to 0
        $display("[TB] seq counter wrap");
        cyc(1, 0, 0, 7'd0, 1'b0, '0, '0, "wrap_idle");
        for (int k = 0; k < 16; k++) begin
            if (TRAP_BUILD) begin
                cyc(1, 1, 1, T_RTYPE, 1'b0, '0, '0, "wrap_f");
                cyc(1, 1, 1, 7'd0,    1'b0, '0, '0, "wrap_d");
                cyc(1, 1, 1, 7'd0,    1'b0, '0, '0, "wrap_e");
                cyc(1, 1, 1, 7'd0,    1'b0, '0, '0, "wrap_w");
            end else begin
                cyc(1, 1, 1, T_BAD, 1'b0, '0, '0, "wrap_f");
                cyc(1, 1, 1, 7'd0,  1'b0, '0, '0, "wrap_d");
            end
            if (k == 14) chkc("wrap_at_15", instr_count, 4'd15);
        end
        cyc(1, 0, 0, 7'd0, 1'b1, 12'b100000000000, 4'd0, "wrap_zero");

        // Randomized traffic against the reference model
        $display("[TB] seq random");
        do_reset();
        model_on = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            logic       e, ia, da;
            logic [6:0] op;
            int         r;
            e  = ($urandom_range(0, 99) < 85);
            ia = $urandom_range(0, 1);
            da = $urandom_range(0, 1);
            r  = $urandom_range(0, TRAP_BUILD ? 3 : 4);
            case (r)
                0:       op = T_LOAD;
                1:       op = T_STORE;
                2:       op = T_RTYPE;
                3:       op = T_ITYPE;
                default: op = 7'($urandom_range(0, 127));
            endcase
            cyc(e, ia, da, op, 1'b0, '0, '0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
